// File: rtl/kmeans_pkg.sv
// kmeans_pkg: shared types and constants for the k-means centroid update stage
package kmeans_pkg;
  typedef logic [31:0] coord_t;
  typedef logic [63:0] sum_t;
  typedef logic [31:0] count_t;
  localparam int DIV_STEPS = 64;
  typedef enum logic [2:0] {IDLE, LOAD, DIV, WRITE, FINISH} upd_state_t;
endpackage

// File: rtl/serial_divider.sv
// serial_divider: 64/32 restoring divider, one quotient bit per cycle, MSB first
module serial_divider
  import kmeans_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] dividend,
  input  logic [31:0] divisor,
  input  logic        start,
  output logic [63:0] quotient,
  output logic        ready
);
  localparam int CW = $clog2(DIV_STEPS);
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  coord_t        rem_q, rem_d;
  sum_t          quo_q, quo_d;
  logic [32:0]   rem_sh, rem_nx;
  logic          ge;
  // ready is raised during the final step so the caller can leave on the same edge that
  // latches the last quotient bit
  always_comb begin
    rem_sh   = {rem_q, quo_q[63]};
    ge       = rem_sh >= {1'b0, divisor};
    rem_nx   = ge ? rem_sh - {1'b0, divisor} : rem_sh;
    ready    = busy_q && cnt_q == CW'(DIV_STEPS - 1);
    busy_d   = start ? 1'b1 : busy_q && !ready;
    cnt_d    = start ? '0 : busy_q ? cnt_q + 1'b1 : cnt_q;
    rem_d    = start ? '0 : busy_q ? rem_nx[31:0] : rem_q;
    quo_d    = start ? dividend : busy_q ? {quo_q[62:0], ge} : quo_q;
    quotient = quo_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
    end
  end
endmodule

// File: rtl/centroid_update.sv
// centroid_update: walks every (cluster, dimension), divides sum by count with one shared
// serial divider, writes new centroids and reports convergence against the old ones
module centroid_update
  import kmeans_pkg::*;
#(
  parameter int n = 8,
  parameter int d = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [2**n-1:0][d-1:0][63:0]    sums,
  input  logic [2**n-1:0][31:0]           counts,
  input  logic [2**n-1:0][d-1:0][31:0]    centroids,
  input  logic [31:0]                     threshold,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            converged,
  output logic [2**n-1:0][d-1:0][31:0]    new_centroids
);
  localparam int K  = 2**n;
  localparam int JW = d > 1 ? $clog2(d) : 1;
  localparam logic [JW-1:0] J_LAST = JW'(d - 1);
  upd_state_t                  state_q, state_d;
  logic [n-1:0]                i_q, i_d;
  logic [JW-1:0]               j_q, j_d;
  logic                        all_ok_q, all_ok_d;
  logic                        conv_q, conv_d;
  logic [K-1:0][d-1:0][31:0]   new_q, new_d;
  sum_t                        sum_cur, div_quo;
  count_t                      cnt_cur;
  coord_t                      old_cur, q;
  logic [32:0]                 diff, mag;
  logic                        div_start, div_ready, last, miss;
  serial_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .dividend (sum_cur),
    .divisor  (cnt_cur),
    .start    (div_start),
    .quotient (div_quo),
    .ready    (div_ready)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      i_q      <= '0;
      j_q      <= '0;
      all_ok_q <= 1'b0;
      conv_q   <= 1'b0;
      new_q    <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      all_ok_q <= all_ok_d;
      conv_q   <= conv_d;
      new_q    <= new_d;
    end
  end
  always_comb begin
    sum_cur = sums[i_q][j_q];
    cnt_cur = counts[i_q];
    old_cur = centroids[i_q][j_q];
    last    = i_q == '1 && j_q == J_LAST;
    // empty clusters keep their old position; oversized quotients saturate
    q       = cnt_cur == '0 ? old_cur : (|div_quo[63:32] ? '1 : div_quo[31:0]);
    diff    = {1'b0, q} - {1'b0, old_cur};
    mag     = diff[32] ? -diff : diff;
    miss    = mag > {1'b0, threshold};
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? LOAD : IDLE;
      LOAD:    state_d = cnt_cur == '0 ? WRITE : DIV;
      DIV:     state_d = div_ready ? WRITE : DIV;
      WRITE:   state_d = last ? FINISH : LOAD;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    i_d       = i_q;
    j_d       = j_q;
    all_ok_d  = all_ok_q;
    conv_d    = conv_q;
    new_d     = new_q;
    div_start = state_q == LOAD && cnt_cur != '0;
    if (state_q == IDLE && start) begin
      i_d      = '0;
      j_d      = '0;
      all_ok_d = 1'b1;
    end
    if (state_q == WRITE) begin
      new_d[i_q][j_q] = q;
      all_ok_d        = all_ok_q && !miss;
      j_d             = j_q == J_LAST ? '0 : j_q + 1'b1;
      i_d             = j_q == J_LAST ? i_q + 1'b1 : i_q;
      conv_d          = last ? all_ok_q && !miss : conv_q;
    end
    busy          = state_q != IDLE;
    done          = state_q == FINISH;
    converged     = conv_q;
    new_centroids = new_q;
  end
endmodule

// File: tb/tb_centroid_update.sv
// tb_centroid_update: directed checks on a 2x2 instance, randomized checks on a 4x3 instance
module tb_centroid_update;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [1:0][1:0][63:0] a_sums;
  logic [1:0][31:0]      a_counts;
  logic [1:0][1:0][31:0] a_cent, a_new;
  logic [31:0]           a_thr;
  logic                  a_start = 0, a_busy, a_done, a_conv;
  logic [3:0][2:0][63:0] b_sums;
  logic [3:0][31:0]      b_counts;
  logic [3:0][2:0][31:0] b_cent, b_new;
  logic [31:0]           b_thr;
  logic                  b_start = 0, b_busy, b_done, b_conv;
  int n_chk = 0, n_pass = 0;
  centroid_update #(.n(1), .d(2)) ua (
    .clk(clk), .rst(rst), .sums(a_sums), .counts(a_counts), .centroids(a_cent),
    .threshold(a_thr), .start(a_start), .busy(a_busy), .done(a_done),
    .converged(a_conv), .new_centroids(a_new));
  centroid_update #(.n(2), .d(3)) ub (
    .clk(clk), .rst(rst), .sums(b_sums), .counts(b_counts), .centroids(b_cent),
    .threshold(b_thr), .start(b_start), .busy(b_busy), .done(b_done),
    .converged(b_conv), .new_centroids(b_new));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [31:0] ref_q(logic [63:0] s, logic [31:0] c, logic [31:0] old);
    logic [63:0] quo;
    if (c == 0) return old;
    quo = s / {32'b0, c};
    return quo > 64'hFFFF_FFFF ? 32'hFFFF_FFFF : quo[31:0];
  endfunction
  function automatic bit close(logic [31:0] a, logic [31:0] b, logic [31:0] t);
    longint df = longint'(a) - longint'(b);
    if (df < 0) df = -df;
    return df <= longint'(t);
  endfunction
  // start in the current cycle (cycle 0); lat is the cycle index in which done is seen
  task automatic run(input bit on_b, input int extra_at, output int lat);
    lat = -1;
    if (on_b) b_start = 1; else a_start = 1;
    for (int cyc = 1; cyc <= 5000; cyc++) begin
      @(posedge clk); #1;
      a_start = 0;
      b_start = 0;
      if (cyc == extra_at) begin
        if (on_b) b_start = 1; else a_start = 1;
      end
      if ((on_b ? b_done : a_done) === 1'b1) begin
        lat = cyc;
        break;
      end
    end
    if (lat < 0) chk("timeout", 0, 1);
  endtask
  task automatic check_a(input string tag, input int lat);
    int exp_lat = 1;
    bit ok = 1;
    logic [31:0] e;
    for (int i = 0; i < 2; i++) begin
      exp_lat += a_counts[i] != 0 ? 2 * 66 : 2 * 2;
      for (int j = 0; j < 2; j++) begin
        e = ref_q(a_sums[i][j], a_counts[i], a_cent[i][j]);
        ok &= close(e, a_cent[i][j], a_thr);
        chk($sformatf("%s new[%0d][%0d]", tag, i, j), a_new[i][j], e);
      end
    end
    chk({tag, " conv"}, a_conv, ok);
    chk({tag, " latency"}, lat, exp_lat);
  endtask
  task automatic setup_basic(input logic [31:0] thr);
    a_sums   = '0;
    a_sums[0][0] = 10;
    a_sums[0][1] = 20;
    a_counts = '0;
    a_counts[0] = 2;
    a_cent[0][0] = 4;
    a_cent[0][1] = 9;
    a_cent[1][0] = 7;
    a_cent[1][1] = 7;
    a_thr = thr;
  endtask
  initial begin
    int lat, nd, exp_lat;
    bit ok;
    logic [31:0] e;
    setup_basic(1);
    b_sums = '0; b_counts = '0; b_cent = '0; b_thr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", a_busy, 0);
    chk("rst done", a_done, 0);
    chk("rst conv", a_conv, 0);
    chk("rst new", a_new, 0);
    rst = 0;
    @(posedge clk); #1;
    run(0, 0, lat);
    chk("basic busy@done", a_busy, 1);
    chk("basic lat", lat, 137);
    chk("basic new00", a_new[0][0], 5);
    chk("basic new01", a_new[0][1], 10);
    chk("basic new10", a_new[1][0], 7);
    chk("basic new11", a_new[1][1], 7);
    chk("basic conv", a_conv, 1);
    @(posedge clk); #1;
    chk("basic busy after", a_busy, 0);
    chk("basic done pulse", a_done, 0);
    setup_basic(0);
    run(0, 0, lat);
    chk("thr0 new01", a_new[0][1], 10);
    chk("thr0 conv", a_conv, 0);
    check_a("thr0", lat);
    @(posedge clk); #1;
    a_sums[0][0] = 7;
    a_sums[0][1] = 21;
    a_sums[1][0] = 64'd1 << 40;
    a_sums[1][1] = 5;
    a_counts[0] = 2;
    a_counts[1] = 1;
    a_thr = 32'hFFFF_FFFF;
    run(0, 0, lat);
    chk("trunc 7/2", a_new[0][0], 3);
    chk("sat 2^40/1", a_new[1][0], 32'hFFFF_FFFF);
    check_a("trunc", lat);
    @(posedge clk); #1;
    a_counts[1] = 512;
    run(0, 0, lat);
    chk("2^40/2^9", a_new[1][0], 32'h8000_0000);
    check_a("div512", lat);
    @(posedge clk); #1;
    setup_basic(1);
    a_start = 1;
    repeat (100) begin
      @(posedge clk); #1;
      a_start = 0;
    end
    chk("mid-div busy", a_busy, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort busy", a_busy, 0);
    chk("abort done", a_done, 0);
    chk("abort conv", a_conv, 0);
    chk("abort new", a_new, 0);
    run(0, 0, lat);
    check_a("after abort", lat);
    @(posedge clk); #1;
    run(0, 50, lat);
    check_a("extra start", lat);
    nd = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (a_done === 1'b1 || a_busy === 1'b1) nd++;
    end
    chk("extra start ignored", nd, 0);
    setup_basic(1);
    run(0, 0, lat);
    a_start = 1;
    @(posedge clk); #1;
    chk("start in done cycle ignored", a_busy, 0);
    run(0, 0, lat);
    check_a("back-to-back", lat);
    for (int it = 0; it < 100; it++) begin
      @(posedge clk); #1;
      exp_lat = 1;
      ok = 1;
      b_thr = ($urandom_range(3) == 0) ? 32'd10 : $urandom_range(6);
      for (int i = 0; i < 4; i++) begin
        b_counts[i] = $urandom_range(1) == 0 ? 32'd0 :
                      ($urandom_range(3) == 0 ? 32'd1 : $urandom >> $urandom_range(31));
        exp_lat += b_counts[i] != 0 ? 3 * 66 : 3 * 2;
        for (int j = 0; j < 3; j++) begin
          b_sums[i][j] = {$urandom, $urandom} >> $urandom_range(63);
          e = ref_q(b_sums[i][j], b_counts[i], $urandom);
          b_cent[i][j] = b_counts[i] == 0 ? e : e + 32'($urandom_range(10)) - 32'd5;
          ok &= close(e, b_cent[i][j], b_thr);
        end
      end
      run(1, 0, lat);
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 3; j++)
          chk($sformatf("rnd%0d new[%0d][%0d]", it, i, j), b_new[i][j],
              ref_q(b_sums[i][j], b_counts[i], b_cent[i][j]));
      chk($sformatf("rnd%0d conv", it), b_conv, ok);
      chk($sformatf("rnd%0d latency", it), lat, exp_lat);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
